// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: default memory depth, FSM states, branch-field constants.
package inst_fetch_pkg;

   localparam int unsigned CODE_MEM_SIZE_DEF = 256;

   typedef enum logic {
      F_IDLE = 1'b0,
      F_RUN  = 1'b1
   } fetch_state_e;

   // Condition / branch field encodings consumed by decode and execute.
   localparam logic [3:0] COND_AL      = 4'h0;
   localparam logic [3:0] COND_EQ      = 4'h1;
   localparam logic [3:0] COND_NE      = 4'h2;
   localparam logic [3:0] COND_LT      = 4'h3;
   localparam logic [3:0] COND_GE      = 4'h4;
   localparam logic [5:0] BRANCH_CODE  = 6'h2C;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_code_mem.sv
// Code memory: one synchronous write port, one registered read port with enable.
// A same-word read and write in one cycle returns the old word.
module code_mem #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, fetch FSM, code memory and accepted-instruction counter.
// Delivers one word per cycle on a valid/ready handshake and takes branch redirects.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned CODE_MEM_SIZE = CODE_MEM_SIZE_DEF,
   parameter logic [31:0] RESET_PC      = '0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        prog_we,
   input  logic [31:0] prog_addr,
   input  logic [31:0] prog_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [15:0] fetch_count
);

   localparam int unsigned AW = $clog2(CODE_MEM_SIZE);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  inst_pc_q, inst_pc_d;
   logic         valid_q, valid_d;
   logic [15:0]  count_q, count_d;
   logic         issue;
   logic [31:0]  issue_addr;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_pc_d  = inst_pc_q;
      valid_d    = valid_q;
      count_d    = count_q;
      issue      = 1'b0;
      issue_addr = redirect_valid ? word_align(redirect_pc) : pc_q;

      case (state_q)
         F_IDLE: begin
            issue   = 1'b1;
            state_d = F_RUN;
         end
         F_RUN: begin
            // A redirect always issues, discarding any stalled instruction.
            issue = redirect_valid || !valid_q || inst_ready;
         end
         default: state_d = F_IDLE;
      endcase

      if (issue) begin
         pc_d      = issue_addr + 32'd4;
         inst_pc_d = issue_addr;
         valid_d   = 1'b1;
      end

      if (valid_q && inst_ready) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= F_IDLE;
         pc_q      <= RESET_PC;
         inst_pc_q <= '0;
         valid_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_pc_q <= inst_pc_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
      end
   end

   code_mem #(
      .DEPTH (CODE_MEM_SIZE),
      .AW    (AW)
   ) u_code_mem (
      .clk     (clk),
      .reset   (reset),
      .we_i    (prog_we),
      .waddr_i (prog_addr[AW+1:2]),
      .wdata_i (prog_data),
      .re_i    (issue),
      .raddr_i (issue_addr[AW+1:2]),
      .rdata_o (inst)
   );

   logic unused_addr_bits;
   assign unused_addr_bits = ^{prog_addr[31:AW+2], prog_addr[1:0], redirect_pc[1:0]};

   assign inst_valid  = valid_q;
   assign inst_pc     = inst_pc_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector table through a scoreboard queue on two
// configurations (256 words / PC 0, and 16 words / PC 0x20), plus a counter-wrap run.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        reset, prog_we, redirect_valid, inst_ready;
   logic [31:0] prog_addr, prog_data, redirect_pc;

   logic        a_valid, b_valid;
   logic [31:0] a_inst, b_inst, a_pc, b_pc;
   logic [15:0] a_cnt, b_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   inst_fetch #(.CODE_MEM_SIZE(256), .RESET_PC(32'h0)) u_a (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(a_valid), .inst_ready(inst_ready), .inst(a_inst), .inst_pc(a_pc),
      .fetch_count(a_cnt)
   );

   inst_fetch #(.CODE_MEM_SIZE(16), .RESET_PC(32'h20)) u_b (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(b_valid), .inst_ready(inst_ready), .inst(b_inst), .inst_pc(b_pc),
      .fetch_count(b_cnt)
   );

   typedef struct {
      bit          sel;
      bit          rst, rdy, rv;
      logic [31:0] rpc;
      bit          we;
      logic [31:0] waddr, wdata;
      bit          ev;
      logic [31:0] epc, eins;
      logic [15:0] ecnt;
   } vec_t;

   typedef struct {
      int          id;
      bit          sel;
      bit          v;
      logic [31:0] pc, ins;
      logic [15:0] cnt;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   localparam logic [31:0] NEW5 = 32'hDEAD_BEEF;

   function automatic logic [31:0] dw(input int unsigned w);
      return 32'hC0DE_0000 | w;
   endfunction

   function automatic vec_t mk(bit sel, bit rst, bit rdy, bit rv, logic [31:0] rpc,
                               bit we, logic [31:0] wa, logic [31:0] wd,
                               bit ev, logic [31:0] epc, logic [31:0] eins, logic [15:0] ecnt);
      vec_t t;
      t.sel = sel; t.rst = rst; t.rdy = rdy; t.rv = rv; t.rpc = rpc;
      t.we = we; t.waddr = wa; t.wdata = wd;
      t.ev = ev; t.epc = epc; t.eins = eins; t.ecnt = ecnt;
      return t;
   endfunction

   task automatic check_front();
      exp_t        e;
      logic        v;
      logic [31:0] pc, ins;
      logic [15:0] cnt;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: queue empty, nothing expected");
         return;
      end
      e   = exp_q.pop_front();
      v   = e.sel ? b_valid : a_valid;
      pc  = e.sel ? b_pc    : a_pc;
      ins = e.sel ? b_inst  : a_inst;
      cnt = e.sel ? b_cnt   : a_cnt;
      if (v !== e.v || pc !== e.pc || ins !== e.ins || cnt !== e.cnt) begin
         errors++;
         $display("FAIL vec%0d dut%s: got v=%0b pc=%h inst=%h cnt=%h, expected v=%0b pc=%h inst=%h cnt=%h",
                  e.id, e.sel ? "B" : "A", v, pc, ins, cnt, e.v, e.pc, e.ins, e.cnt);
      end
   endtask

   task automatic apply(input vec_t t, input int id);
      exp_t e;
      reset          = t.rst;
      inst_ready     = t.rdy;
      redirect_valid = t.rv;
      redirect_pc    = t.rpc;
      prog_we        = t.we;
      prog_addr      = t.waddr;
      prog_data      = t.wdata;
      e.id = id; e.sel = t.sel; e.v = t.ev; e.pc = t.epc; e.ins = t.eins; e.cnt = t.ecnt;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_front();
   endtask

   task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;

      // Configuration A: 256 words, RESET_PC 0
      vecs.push_back(mk(0,1,0,0,0,           0,0,0,     0,32'h0,        32'h0,  16'd0));
      vecs.push_back(mk(0,0,1,0,0,           0,0,0,     1,32'h0,        dw(0),  16'd0));
      vecs.push_back(mk(0,0,1,0,0,           0,0,0,     1,32'h4,        dw(1),  16'd1));
      vecs.push_back(mk(0,0,0,0,0,           0,0,0,     1,32'h4,        dw(1),  16'd1));
      vecs.push_back(mk(0,0,0,0,0,           0,0,0,     1,32'h4,        dw(1),  16'd1));
      vecs.push_back(mk(0,0,0,0,0,           0,0,0,     1,32'h4,        dw(1),  16'd1));
      vecs.push_back(mk(0,0,1,0,0,           0,0,0,     1,32'h8,        dw(2),  16'd2));
      vecs.push_back(mk(0,0,0,0,0,           0,0,0,     1,32'h8,        dw(2),  16'd2));
      vecs.push_back(mk(0,0,0,1,32'h41,      0,0,0,     1,32'h40,       dw(16), 16'd2));
      vecs.push_back(mk(0,0,1,0,0,           0,0,0,     1,32'h44,       dw(17), 16'd3));
      vecs.push_back(mk(0,0,1,0,0,           0,0,0,     1,32'h48,       dw(18), 16'd4));
      vecs.push_back(mk(0,0,1,1,32'h8,       0,0,0,     1,32'h8,        dw(2),  16'd5));
      vecs.push_back(mk(0,0,1,0,0,           0,0,0,     1,32'hC,        dw(3),  16'd6));
      vecs.push_back(mk(0,0,1,0,0,           0,0,0,     1,32'h10,       dw(4),  16'd7));
      vecs.push_back(mk(0,0,1,0,0,           1,32'h14,NEW5, 1,32'h14,   dw(5),  16'd8));
      vecs.push_back(mk(0,0,1,1,32'h14,      0,0,0,     1,32'h14,       NEW5,   16'd9));
      vecs.push_back(mk(0,0,1,0,0,           0,0,0,     1,32'h18,       dw(6),  16'd10));
      vecs.push_back(mk(0,0,0,0,0,           0,0,0,     1,32'h18,       dw(6),  16'd10));
      vecs.push_back(mk(0,1,0,0,0,           0,0,0,     0,32'h0,        32'h0,  16'd0));
      // Configuration B: 16 words (upper preload words alias words 0..15), RESET_PC 0x20
      vecs.push_back(mk(1,1,0,0,0,           0,0,0,     0,32'h0,        32'h0,  16'd0));
      vecs.push_back(mk(1,0,1,0,0,           0,0,0,     1,32'h20,       dw(24), 16'd0));
      vecs.push_back(mk(1,0,1,1,32'h34,      0,0,0,     1,32'h34,       dw(29), 16'd1));
      vecs.push_back(mk(1,0,1,0,0,           0,0,0,     1,32'h38,       dw(30), 16'd2));
      vecs.push_back(mk(1,0,1,0,0,           0,0,0,     1,32'h3C,       dw(31), 16'd3));
      vecs.push_back(mk(1,0,1,0,0,           0,0,0,     1,32'h40,       dw(16), 16'd4));
      vecs.push_back(mk(1,0,1,1,32'hFFFFFFFC,0,0,0,     1,32'hFFFFFFFC, dw(31), 16'd5));
      vecs.push_back(mk(1,0,1,0,0,           0,0,0,     1,32'h0,        dw(16), 16'd6));
      vecs.push_back(mk(1,0,0,0,0,           0,0,0,     1,32'h0,        dw(16), 16'd6));
      vecs.push_back(mk(1,1,0,0,0,           0,0,0,     0,32'h0,        32'h0,  16'd0));
      vecs.push_back(mk(1,0,0,0,0,           0,0,0,     1,32'h20,       dw(24), 16'd0));
      vecs.push_back(mk(1,0,0,0,0,           0,0,0,     1,32'h20,       dw(24), 16'd0));

      // Preload words 0..31 while reset is held
      @(negedge clk);
      for (int unsigned w = 0; w < 32; w++) begin
         prog_we = 1'b1; prog_addr = w * 4; prog_data = dw(w);
         @(posedge clk);
         #1;
      end
      prog_we = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], i);
      end

      // fetch_count wrap on configuration A with inst_ready held high
      reset = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; prog_we = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk16("count_after_idle", a_cnt, 16'h0000);
      for (int n = 0; n < 65535; n++) begin
         @(posedge clk); #1;
      end
      chk16("count_max", a_cnt, 16'hFFFF);
      @(posedge clk); #1;
      chk16("count_wrap", a_cnt, 16'h0000);

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
